// File: rtl/rll_enc_ctrl.sv
// Frame sequencer for the RLL encoder: streams a byte frame MSB-first into the
// encoder, pads with zeros until every fed bit is coded, and forwards codewords.
module rll_enc_ctrl #(
  parameter int LEN_W     = 8,
  parameter int MAX_PAD   = 4,
  parameter int DRAIN_CYC = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  input  logic [7:0]       s_data_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  output logic             enc_rst_o,
  output logic             enc_bit_o,
  input  logic [1:0]       enc_valid_i,
  input  logic [3:0]       enc4_i,
  input  logic [5:0]       enc6_i,
  input  logic [7:0]       enc8_i,
  output logic [7:0]       cw_o,
  output logic [3:0]       cw_len_o,
  output logic             cw_valid_o,
  output logic [15:0]      cw_count_o
);
  // Byte stream: a transfer happens on a rising edge where s_valid_i and
  // s_ready_o are both high; s_ready_o never depends on s_valid_i.

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT_FIRST, ST_SHIFT, ST_PAD, ST_DRAIN
  } state_t;

  localparam int PAD_W = $clog2(MAX_PAD + 1);
  localparam int DRN_W = $clog2(DRAIN_CYC + 1);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   ld_q, ld_d;
  logic [7:0]         shift_q, shift_d;
  logic [2:0]         idx_q, idx_d;
  logic [7:0]         buf_q, buf_d;
  logic               buf_full_q, buf_full_d;
  logic [4:0]         pend_q, pend_d;
  logic [PAD_W-1:0]   pad_q, pad_d;
  logic [DRN_W-1:0]   drn_q, drn_d;
  logic               feed_q, feed_d;
  logic               enc_rst_q, enc_rst_d;
  logic               enc_bit_q, enc_bit_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [7:0]         cw_q, cw_d;
  logic [3:0]         cw_len_q, cw_len_d;
  logic               cw_valid_q, cw_valid_d;
  logic [15:0]        cw_cnt_q, cw_cnt_d;

  logic       hs;
  logic [2:0] dec;
  logic [5:0] pend_sum;
  logic [5:0] pend_next;
  logic       pend_uflow;
  logic [4:0] pend_new;
  logic       go_done;
  logic       go_err;

  assign s_ready_o = (state_q == ST_WAIT_FIRST) ||
                     ((state_q == ST_SHIFT) && !buf_full_q && (acc_q < len_q));
  assign hs        = s_valid_i && s_ready_o;

  always_comb begin
    dec = 3'd0;
    if (!enc_rst_q) begin
      case (enc_valid_i)
        2'd1:    dec = 3'd2;
        2'd2:    dec = 3'd3;
        2'd3:    dec = 3'd4;
        default: dec = 3'd0;
      endcase
    end
  end

  // Pending = bits the encoder has sampled but not yet emitted as a codeword.
  assign pend_sum   = {1'b0, pend_q} + {5'd0, feed_q};
  assign pend_uflow = pend_sum < {3'd0, dec};
  assign pend_next  = pend_sum - {3'd0, dec};
  assign pend_new   = pend_next[5] ? 5'h1F : pend_next[4:0];

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    acc_d      = acc_q;
    ld_d       = ld_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    pend_d     = pend_new;
    pad_d      = pad_q;
    drn_d      = drn_q;
    feed_d     = feed_q;
    enc_rst_d  = enc_rst_q;
    enc_bit_d  = enc_bit_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    go_done    = 1'b0;
    go_err     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        enc_rst_d = 1'b1;
        enc_bit_d = 1'b0;
        feed_d    = 1'b0;
        pend_d    = 5'd0;
        if (start_i) begin
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            len_d      = len_i;
            acc_d      = '0;
            ld_d       = '0;
            buf_full_d = 1'b0;
            state_d    = ST_WAIT_FIRST;
          end
        end
      end
      ST_WAIT_FIRST: begin
        if (hs) begin
          shift_d   = s_data_i;
          enc_bit_d = s_data_i[7];
          idx_d     = 3'd7;
          feed_d    = 1'b1;
          enc_rst_d = 1'b0;
          acc_d     = acc_q + LEN_W'(1);
          ld_d      = LEN_W'(1);
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (hs) begin
          buf_d      = s_data_i;
          buf_full_d = 1'b1;
          acc_d      = acc_q + LEN_W'(1);
        end
        if (idx_q != 3'd0) begin
          idx_d     = idx_q - 3'd1;
          enc_bit_d = shift_q[idx_q - 3'd1];
        end else if (ld_q == len_q) begin
          enc_bit_d = 1'b0;
          if (pend_new == 5'd0) begin
            go_done = 1'b1;
          end else begin
            state_d = ST_PAD;
            pad_d   = PAD_W'(1);
          end
        end else if (buf_full_q) begin
          shift_d    = buf_q;
          enc_bit_d  = buf_q[7];
          idx_d      = 3'd7;
          ld_d       = ld_q + LEN_W'(1);
          buf_full_d = 1'b0;
        end else begin
          go_err = 1'b1;
        end
      end
      ST_PAD: begin
        if (pend_new == 5'd0) begin
          go_done = 1'b1;
        end else if (pad_q < PAD_W'(MAX_PAD)) begin
          pad_d = pad_q + PAD_W'(1);
        end else begin
          state_d = ST_DRAIN;
          feed_d  = 1'b0;
          drn_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (pend_new == 5'd0) begin
          go_done = 1'b1;
        end else if (drn_q == DRN_W'(DRAIN_CYC - 1)) begin
          go_err = 1'b1;
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q == ST_SHIFT || state_q == ST_PAD || state_q == ST_DRAIN) && pend_uflow) begin
      go_err = 1'b1;
    end

    if (go_err || go_done) begin
      state_d    = ST_IDLE;
      enc_rst_d  = 1'b1;
      enc_bit_d  = 1'b0;
      feed_d     = 1'b0;
      buf_full_d = 1'b0;
      err_d      = go_err;
      done_d     = !go_err;
    end
  end

  // Codewords are left-aligned; anything the encoder shows while held in reset is dropped.
  always_comb begin
    cw_valid_d = 1'b0;
    cw_d       = 8'd0;
    cw_len_d   = 4'd0;
    cw_cnt_d   = cw_cnt_q;
    if (state_q == ST_IDLE && start_i && len_i != '0) begin
      cw_cnt_d = 16'd0;
    end
    if (!enc_rst_q && enc_valid_i != 2'd0) begin
      cw_valid_d = 1'b1;
      case (enc_valid_i)
        2'd1:    begin cw_d = {enc4_i, 4'b0000}; cw_len_d = 4'd4; end
        2'd2:    begin cw_d = {enc6_i, 2'b00};   cw_len_d = 4'd6; end
        default: begin cw_d = enc8_i;            cw_len_d = 4'd8; end
      endcase
      if (cw_cnt_q != 16'hFFFF) cw_cnt_d = cw_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      acc_q      <= '0;
      ld_q       <= '0;
      shift_q    <= 8'd0;
      idx_q      <= 3'd0;
      buf_q      <= 8'd0;
      buf_full_q <= 1'b0;
      pend_q     <= 5'd0;
      pad_q      <= '0;
      drn_q      <= '0;
      feed_q     <= 1'b0;
      enc_rst_q  <= 1'b1;
      enc_bit_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      cw_q       <= 8'd0;
      cw_len_q   <= 4'd0;
      cw_valid_q <= 1'b0;
      cw_cnt_q   <= 16'd0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      acc_q      <= acc_d;
      ld_q       <= ld_d;
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      pend_q     <= pend_d;
      pad_q      <= pad_d;
      drn_q      <= drn_d;
      feed_q     <= feed_d;
      enc_rst_q  <= enc_rst_d;
      enc_bit_q  <= enc_bit_d;
      done_q     <= done_d;
      err_q      <= err_d;
      cw_q       <= cw_d;
      cw_len_q   <= cw_len_d;
      cw_valid_q <= cw_valid_d;
      cw_cnt_q   <= cw_cnt_d;
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign enc_rst_o  = enc_rst_q;
  assign enc_bit_o  = enc_bit_q;
  assign cw_o       = cw_q;
  assign cw_len_o   = cw_len_q;
  assign cw_valid_o = cw_valid_q;
  assign cw_count_o = cw_cnt_q;

endmodule

// File: tb/tb_rll_enc_ctrl.sv
// Bench for rll_enc_ctrl with a (2,7) RLL encoder model that answers in the
// same cycle the completing bit is presented.
module tb_rll_enc_ctrl;
  localparam int MAX_PAD   = 4;
  localparam int DRAIN_CYC = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [7:0]  len_i;
  logic        busy_o, done_o, err_o;
  logic [7:0]  s_data_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic        enc_rst_o, enc_bit_o;
  logic [1:0]  enc_valid_i;
  logic [3:0]  enc4_i;
  logic [5:0]  enc6_i;
  logic [7:0]  enc8_i;
  logic [7:0]  cw_o;
  logic [3:0]  cw_len_o;
  logic        cw_valid_o;
  logic [15:0] cw_count_o;

  rll_enc_ctrl #(.LEN_W(8), .MAX_PAD(MAX_PAD), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .enc_rst_o(enc_rst_o), .enc_bit_o(enc_bit_o), .enc_valid_i(enc_valid_i),
    .enc4_i(enc4_i), .enc6_i(enc6_i), .enc8_i(enc8_i),
    .cw_o(cw_o), .cw_len_o(cw_len_o), .cw_valid_o(cw_valid_o), .cw_count_o(cw_count_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- encoder model ----------------
  logic [3:0] m_bits_q = 4'd0;
  logic [2:0] m_k_q = 3'd0;
  logic [3:0] m_cand;
  logic [2:0] m_ck;
  logic [1:0] m_code;
  logic [7:0] m_cw;
  logic       never_valid = 1'b0;

  always_comb begin
    m_cand = {m_bits_q[2:0], enc_bit_o};
    m_ck   = m_k_q + 3'd1;
    m_code = 2'd0;
    m_cw   = 8'h00;
    if (m_ck == 3'd2 && m_cand[1]) begin
      m_code = 2'd1;
      m_cw   = m_cand[0] ? 8'h80 : 8'h40;
    end else if (m_ck == 3'd3 && m_cand[2:0] != 3'b001) begin
      m_code = 2'd2;
      case (m_cand[2:0])
        3'b000:  m_cw = 8'h10;
        3'b010:  m_cw = 8'h90;
        default: m_cw = 8'h20;
      endcase
    end else if (m_ck == 3'd4) begin
      m_code = 2'd3;
      m_cw   = m_cand[0] ? 8'h08 : 8'h24;
    end
  end

  // Junk on the encoder outputs while it is held in reset or a lane is unused.
  always_comb begin
    if (enc_rst_o) begin
      enc_valid_i = 2'd3;
      enc4_i      = 4'hF;
      enc6_i      = 6'h3F;
      enc8_i      = 8'hFF;
    end else begin
      enc_valid_i = never_valid ? 2'd0 : m_code;
      enc4_i      = (m_code == 2'd1) ? m_cw[7:4] : 4'hA;
      enc6_i      = (m_code == 2'd2) ? m_cw[7:2] : 6'h2A;
      enc8_i      = (m_code == 2'd3) ? m_cw : 8'hA5;
    end
  end

  always @(posedge clk) begin
    if (enc_rst_o) begin
      m_bits_q <= 4'd0;
      m_k_q    <= 3'd0;
    end else if (m_code != 2'd0) begin
      m_bits_q <= 4'd0;
      m_k_q    <= 3'd0;
    end else begin
      m_bits_q <= m_cand;
      m_k_q    <= m_ck;
    end
  end

  // ---------------- codeword scoreboard ----------------
  logic [11:0] exp_cw_q[$];
  int          cw_total = 0;

  always @(posedge clk) begin
    if (!enc_rst_o && enc_valid_i != 2'd0) begin
      case (enc_valid_i)
        2'd1:    exp_cw_q.push_back({m_cw, 4'd4});
        2'd2:    exp_cw_q.push_back({m_cw, 4'd6});
        default: exp_cw_q.push_back({m_cw, 4'd8});
      endcase
      cw_total <= cw_total + 1;
    end
  end

  always @(negedge clk) begin
    logic [11:0] e;
    if (cw_valid_o) begin
      e = (exp_cw_q.size() > 0) ? exp_cw_q.pop_front() : 12'hFFF;
      check_eq("cw", {cw_o, cw_len_o}, e);
    end else if (!rst_i) begin
      check_eq("cw_len_idle", cw_len_o, 4'd0);
    end
  end

  // ---------------- frame driver / bit scoreboard ----------------
  logic [7:0] frame_b[16];
  logic [0:0] exp_bit_q[$];

  function automatic bit code_done(input logic [3:0] p, input int k);
    return (k == 2 && p[1]) || (k == 3 && p[2:0] != 3'b001) || (k == 4);
  endfunction

  function automatic int pads_needed(input int n);
    logic [3:0] p = 4'd0;
    int k = 0;
    int pads = 0;
    for (int i = 0; i < n; i++) begin
      for (int j = 7; j >= 0; j--) begin
        p = {p[2:0], frame_b[i][j]};
        k++;
        if (code_done(p, k)) k = 0;
      end
    end
    while (k != 0) begin
      p = {p[2:0], 1'b0};
      k++;
      pads++;
      if (code_done(p, k)) k = 0;
    end
    return pads;
  endfunction

  task automatic run_frame(input int n, input int stall_at, input bit exp_err,
                           input int exp_zeros, input bit inject);
    int sent = 0, bits = 0, zeros = 0, dn = 0, er = 0, cyc = 0;
    int cw_base;
    bit armed = 0, fin = 0;
    exp_bit_q.delete();
    cw_base = cw_total;
    @(negedge clk);
    start_i = 1'b1;
    len_i   = 8'(n);
    @(negedge clk);
    start_i = 1'b0;
    while (!fin && cyc < 600) begin
      if (armed) begin
        if (done_o) dn++;
        if (err_o)  er++;
        if (!busy_o) begin
          fin = 1;
          check_eq("enc_rst_at_end", enc_rst_o, 1'b1);
        end else if (exp_bit_q.size() > 0) begin
          check_eq("enc_bit", enc_bit_o, exp_bit_q.pop_front());
          bits++;
        end else begin
          check_eq("pad_zero", enc_bit_o, 1'b0);
          zeros++;
        end
      end
      start_i   = inject && (cyc == 6);
      len_i     = (inject && cyc == 6) ? 8'd1 : 8'(n);
      s_valid_i = !fin && (sent < n) && (sent != stall_at);
      s_data_i  = frame_b[sent % 16];
      if (s_valid_i && s_ready_o) begin
        for (int j = 7; j >= 0; j--) exp_bit_q.push_back(s_data_i[j]);
        sent++;
        armed = 1;
      end
      cyc++;
      if (!fin) @(negedge clk);
    end
    s_valid_i = 1'b0;
    start_i   = 1'b0;
    check_eq("frame_end", fin, 1'b1);
    check_eq("handshakes", sent, (stall_at < 0) ? n : stall_at);
    check_eq("data_bits", bits, 8 * sent);
    check_eq("zero_cycles", zeros, exp_zeros);
    check_eq("done_cnt", dn, exp_err ? 0 : 1);
    check_eq("err_cnt", er, exp_err ? 1 : 0);
    check_eq("cw_count", cw_count_o, cw_total - cw_base);
    @(negedge clk);
    check_eq("single_pulse", {done_o, err_o}, 2'b00);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_i     = 1'b1;
    start_i   = 1'b0;
    len_i     = 8'd0;
    s_data_i  = 8'd0;
    s_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_enc_rst", enc_rst_o, 1'b1);
    check_eq("rst_outs", {busy_o, done_o, err_o, s_ready_o, enc_bit_o, cw_valid_o}, 6'd0);
    check_eq("rst_cw", {cw_o, cw_len_o, cw_count_o}, 28'd0);
    rst_i = 1'b0;
    @(negedge clk);

    // empty frame
    start_i = 1'b1;
    len_i   = 8'd0;
    @(negedge clk);
    start_i = 1'b0;
    check_eq("len0_done", done_o, 1'b1);
    check_eq("len0_state", {busy_o, s_ready_o, enc_rst_o}, 3'b001);
    @(negedge clk);
    check_eq("len0_after", {done_o, s_ready_o, enc_rst_o}, 3'b001);

    frame_b[0] = 8'hC4;
    run_frame(1, -1, 1'b0, pads_needed(1), 1'b0);

    frame_b[0] = 8'hC4; frame_b[1] = 8'hF1; frame_b[2] = 8'h5D; frame_b[3] = 8'h4C;
    run_frame(4, -1, 1'b0, pads_needed(4), 1'b0);

    frame_b[0] = 8'hC4;
    run_frame(2, 1, 1'b1, 0, 1'b0);

    never_valid = 1'b1;
    frame_b[0] = 8'hC4;
    run_frame(1, -1, 1'b1, MAX_PAD + DRAIN_CYC, 1'b0);
    never_valid = 1'b0;

    for (int i = 0; i < 3; i++) frame_b[i] = 8'($urandom_range(0, 255));
    run_frame(3, -1, 1'b0, pads_needed(3), 1'b1);

    for (int f = 0; f < 4; f++) begin
      int n;
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) frame_b[i] = 8'($urandom_range(0, 255));
      run_frame(n, -1, 1'b0, pads_needed(n), 1'b0);
    end

    // reset in the middle of SHIFT
    @(negedge clk);
    start_i = 1'b1;
    len_i   = 8'd4;
    @(negedge clk);
    start_i   = 1'b0;
    s_valid_i = 1'b1;
    s_data_i  = 8'hA5;
    repeat (14) @(negedge clk);
    check_eq("pre_rst_busy", busy_o, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    check_eq("mid_rst_outs", {enc_rst_o, busy_o, s_ready_o, done_o, err_o}, 5'b10000);
    check_eq("mid_rst_count", cw_count_o, 16'd0);
    s_valid_i = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_pulse", {done_o, err_o}, 2'b00);
    rst_i = 1'b0;
    @(negedge clk);
    check_eq("post_rst_pulse", {done_o, err_o, busy_o}, 3'b000);
    exp_cw_q.delete();

    frame_b[0] = 8'h3C; frame_b[1] = 8'h81;
    run_frame(2, -1, 1'b0, pads_needed(2), 1'b0);

    repeat (3) @(negedge clk);
    check_eq("cw_queue_empty", exp_cw_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
